fx_sequencer: RTL

FX_SEQUENCER -- requirements
Module: fx_sequencer

---
 rtl/fx_sequencer.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/fx_sequencer.sv
// fx_sequencer: feeds x samples one at a time into an external FX pipeline,
// chaining each result back as the next datab operand, and reports the
// final accumulated sum.
//
// Ports
//   clk        : rising-edge clock
//   rst        : asynchronous active-low reset (release synchronised inside)
//   start      : one-cycle run request, sampled only in IDLE
//   n_samples  : number of samples in the run, latched on an accepted start
//   x_valid    : source has a sample on x_data
//   x_data     : IEEE-754 single-precision sample
//   x_ready    : sequencer accepts x_data this cycle (FETCH only)
//   fx_dataa   : x operand to the FX pipeline
//   fx_datab   : running-sum operand to the FX pipeline
//   fx_clk_en  : FX pipeline clock enable, high only while a pair is in flight
//   fx_result  : FX pipeline output
//   busy       : a run is in progress
//   done       : one-cycle pulse on run completion
//   sum        : final sum, stable from done until the next accepted start
module fx_sequencer #(
  parameter int unsigned FX_LATENCY = 32,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] n_samples,
  input  logic             x_valid,
  input  logic [31:0]      x_data,
  output logic             x_ready,
  output logic [31:0]      fx_dataa,
  output logic [31:0]      fx_datab,
  output logic             fx_clk_en,
  input  logic [31:0]      fx_result,
  output logic             busy,
  output logic             done,
  output logic [31:0]      sum
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned LAT_W  = (FX_LATENCY > 1) ? $clog2(FX_LATENCY) : 1;
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(FX_LATENCY - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    ISSUE   = 3'd2,
    CAPTURE = 3'd3,
    FIN     = 3'd4
  } state_t;

  // Reset synchroniser: assertion is immediate, release lands on a clean edge.
  logic [1:0] rst_sync_q;
  logic       rst_n_int;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_n_int = rst_sync_q[1];

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] dataa_q, dataa_d;
  logic [DATA_W-1:0] sum_q, sum_d;
  logic              x_ready_q, x_ready_d;
  logic              clk_en_q, clk_en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state_q   <= IDLE;
      rem_q     <= '0;
      lat_q     <= '0;
      acc_q     <= '0;
      dataa_q   <= '0;
      sum_q     <= '0;
      x_ready_q <= 1'b0;
      clk_en_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      lat_q     <= lat_d;
      acc_q     <= acc_d;
      dataa_q   <= dataa_d;
      sum_q     <= sum_d;
      x_ready_q <= x_ready_d;
      clk_en_q  <= clk_en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Next-state, datapath updates and registered-output decode.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    lat_d   = lat_q;
    acc_d   = acc_q;
    dataa_d = dataa_q;
    sum_d   = sum_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          rem_d   = n_samples;
          acc_d   = '0;
          state_d = (n_samples == '0) ? FIN : FETCH;
        end
      end
      FETCH: begin
        if (x_valid && x_ready_q) begin
          dataa_d = x_data;
          lat_d   = LAT_LOAD;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (lat_q == '0) begin
          state_d = CAPTURE;
        end else begin
          lat_d = lat_q - LAT_W'(1);
        end
      end
      CAPTURE: begin
        acc_d   = fx_result;
        rem_d   = rem_q - CNT_W'(1);
        // Compare before decrement so a full-scale count never wraps.
        state_d = (rem_q != CNT_W'(1)) ? FETCH : FIN;
      end
      FIN: begin
        sum_d   = acc_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the state being entered, so they line up
    // with the state itself; done trails FIN so it coincides with sum.
    x_ready_d = (state_d == FETCH);
    clk_en_d  = (state_d == ISSUE);
    busy_d    = (state_d != IDLE);
    done_d    = (state_q == FIN);
  end

  assign x_ready   = x_ready_q;
  assign fx_dataa  = dataa_q;
  assign fx_datab  = acc_q;
  assign fx_clk_en = clk_en_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign sum       = sum_q;

endmodule
